// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits.
// Each bit is decided by a 3-sample majority vote around mid-bit. False starts are
// rejected. Parity, framing and break status are reported with a one-cycle done pulse.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned UART_BPS  = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rxd,
  output logic                 uart_rx_done,
  output logic [DATA_BITS-1:0] uart_rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned HALF         = BAUD_CNT_MAX / 2;
  localparam int unsigned CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } state_t;

  state_t state, state_next;

  logic rx_s1, rx_s2, rx_s3;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
  logic [3:0] bit_cnt, bit_cnt_next;
  logic samp0, samp1;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic par_bit, par_bit_next;
  logic stop0, stop0_next;

  logic                 done_next;
  logic [DATA_BITS-1:0] data_next;
  logic                 perr_next, ferr_next, brk_next;

  logic wrap, decide, bit_val;
  logic first_stop, is_break, par_x;

  assign wrap    = (baud_cnt == CNT_W'(BAUD_CNT_MAX - 1));
  assign decide  = (baud_cnt == CNT_W'(HALF));
  assign bit_val = (samp0 & samp1) | (samp0 & rx_s2) | (samp1 & rx_s2);

  // Synchroniser plus delay flop; reset to idle-high so reset never fakes a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // First two majority samples; the third is the live synced line at the decision point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp0 <= 1'b1;
      samp1 <= 1'b1;
    end else begin
      if (baud_cnt == CNT_W'(HALF - 2)) samp0 <= rx_s2;
      if (baud_cnt == CNT_W'(HALF - 1)) samp1 <= rx_s2;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      stop0        <= 1'b0;
      uart_rx_done <= 1'b0;
      uart_rx_data <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      state        <= state_next;
      baud_cnt     <= baud_cnt_next;
      bit_cnt      <= bit_cnt_next;
      shift        <= shift_next;
      par_bit      <= par_bit_next;
      stop0        <= stop0_next;
      uart_rx_done <= done_next;
      uart_rx_data <= data_next;
      parity_err   <= perr_next;
      frame_err    <= ferr_next;
      break_det    <= brk_next;
    end
  end

  // Frame status evaluated at the final stop decision.
  always_comb begin
    first_stop = (STOP_BITS == 2) ? stop0 : bit_val;
    is_break   = ~(|shift) && ((PARITY == 0) || !par_bit) && !first_stop;
    par_x      = (^shift) ^ par_bit;
  end

  // Next-state logic and output capture.
  always_comb begin
    state_next    = state;
    baud_cnt_next = wrap ? '0 : baud_cnt + 1'b1;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    par_bit_next  = par_bit;
    stop0_next    = stop0;
    done_next     = 1'b0;
    data_next     = uart_rx_data;
    perr_next     = parity_err;
    ferr_next     = frame_err;
    brk_next      = break_det;

    unique case (state)
      S_IDLE: begin
        baud_cnt_next = '0;
        bit_cnt_next  = '0;
        if (rx_s3 && !rx_s2) state_next = S_START;
      end
      S_START: begin
        if (decide && bit_val) begin
          state_next    = S_IDLE;
          baud_cnt_next = '0;
        end else if (wrap) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (decide) shift_next = {bit_val, shift[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            bit_cnt_next = '0;
            state_next   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (decide) par_bit_next = bit_val;
        if (wrap) begin
          bit_cnt_next = '0;
          state_next   = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          if ((STOP_BITS == 2) && !bit_cnt[0]) begin
            stop0_next = bit_val;
          end else begin
            // Final stop: publish the frame without waiting for the bit to end.
            done_next     = 1'b1;
            data_next     = shift;
            ferr_next     = !bit_val || !first_stop;
            brk_next      = is_break;
            perr_next     = is_break ? 1'b0 :
                            (PARITY == 1) ? !par_x :
                            (PARITY == 2) ? par_x : 1'b0;
            state_next    = is_break ? S_BRK_WAIT : S_IDLE;
            baud_cnt_next = '0;
          end
        end else if (wrap) begin
          bit_cnt_next = 4'd1;
        end
      end
      S_BRK_WAIT: begin
        // Need one full bit period of continuous idle before listening again.
        if (!rx_s2) begin
          baud_cnt_next = '0;
        end else if (wrap) begin
          baud_cnt_next = '0;
          state_next    = S_IDLE;
        end
      end
      default: begin
        state_next    = S_IDLE;
        baud_cnt_next = '0;
      end
    endcase
  end

endmodule
